wb_sequencer: RTL and testbench
===============================

# wb_sequencer

Multicycle writeback sequencer for the register-file write port. It latches a decoded writeback class on `start` and steps through the write cycles that class needs, including a fixed memory-wait interval and the second write for POP. On each write cycle it drives the RegDst selector, the write-data source select and `reg_write`. It sits between the main control FSM and the RegDst/MemToReg muxes in front of the register bank.

## Interface
- `MEM_WAIT`, default 2: cycles spent waiting for memory read data before a memory-sourced write; 0..15; 0 skips the wait state.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; forces IDLE and all outputs to reset values.
- `start`  in  1  request strobe; sampled only in IDLE.
- `wb_op`  in  3  writeback class, sampled with `start`: 0 NONE, 1 RTYPE (rd), 2 ITYPE (rt), 3 JAL (reg 31), 4 PUSH (sp, reg 29), 5 POP (rt from mem, then sp), 6 LOAD (rt from mem), 7 illegal.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in DONE.
- `illegal`  out  1  one-cycle pulse, in the cycle after `start` with `wb_op`=7.
- `regdst_sel`  out  3  RegDst mux select: 000 rt, 001 const 29, 010 const 31, 011 rd, 100 aux.
- `wd_sel`  out  2  write-data select: 0 ALU, 1 MEM, 2 PC, 3 SP_ADJ.
- `reg_write`  out  1  register-bank write enable; high only in WR_A/WR_B.

## Operation
- States: IDLE, WAIT, WR_A, WR_B, DONE.
- `wb_op` is latched into `op_q` on accepted `start`. `start` outside IDLE is ignored, with no queueing.
- From IDLE on `start`:
  - NONE -> DONE.
  - 7 -> DONE, with `illegal`=1 in that DONE cycle and no write.
  - RTYPE/ITYPE/JAL/PUSH -> WR_A.
  - LOAD/POP -> WAIT, counter loaded with MEM_WAIT-1; if MEM_WAIT=0, go straight to WR_A.
- WAIT: counter decrements each cycle; at 0 -> WR_A.
- WR_A: `reg_write`=1 for one cycle, with `regdst_sel`/`wd_sel` per `op_q`:
  - RTYPE: 011/ALU.
  - ITYPE: 000/ALU.
  - JAL: 010/PC.
  - PUSH: 001/SP_ADJ.
  - LOAD: 000/MEM.
  - POP: 000/MEM.
- After WR_A: POP -> WR_B; all others -> DONE.
- WR_B (POP only): `reg_write`=1, `regdst_sel`=001, `wd_sel`=SP_ADJ; -> DONE.
- DONE: `done`=1; -> IDLE. A new `start` is accepted only once the FSM is back in IDLE.
- Outputs are Moore: decoded from state and `op_q` only, with no combinational path from inputs.
- Outside WR_A/WR_B: `regdst_sel`=000, `wd_sel`=0, `reg_write`=0.
- Reset values: state IDLE, `op_q`=0, counter=0, `busy`=0, `done`=0, `illegal`=0, `regdst_sel`=000, `wd_sel`=00, `reg_write`=0.
- Reset mid-operation aborts immediately. Any remaining write is not performed, and no `done` is issued.
- Counter width is max(1, $clog2(MEM_WAIT+1)).

## Timing
- `start` is sampled at edge 0; counts below are cycles after that edge.
- RTYPE/ITYPE/JAL/PUSH: WR_A in cycle 1, DONE in cycle 2, IDLE in cycle 3.
- LOAD, MEM_WAIT=N>0: WAIT for cycles 1..N, WR_A at N+1, DONE at N+2.
- POP, MEM_WAIT=N: WR_A at N+1, WR_B at N+2, DONE at N+3.
- NONE/illegal: DONE in cycle 1.
- Exactly one `reg_write` pulse per op, except POP (two consecutive pulses) and NONE/illegal (zero).
- `busy` rises in cycle 1 and falls in the cycle after DONE.

## Structure
- Shared package `wb_pkg` holds:
  - `wb_op` encodings.
  - RegDst select encodings (RD_RT, RD_SP, RD_RA, RD_RD, RD_AUX).
  - `wd_sel` encodings.
  - State enum.
- The RegDst mux and the main control FSM import the same constants.
- Single module; the wait counter is inline, with no sub-module.

## Test plan
- Reset held with `start`=1, `wb_op`=1 -> all outputs 0, state stays IDLE; after release, no operation has started.
- `start`, `wb_op`=1 -> cycle 1 `reg_write`=1, `regdst_sel`=011, `wd_sel`=0; cycle 2 `done`=1; `busy` high for cycles 1–2.
- MEM_WAIT=2, `wb_op`=5 (POP):
  - cycles 1–2: `reg_write`=0.
  - cycle 3: `reg_write`=1, `regdst_sel`=000, `wd_sel`=1.
  - cycle 4: `reg_write`=1, `regdst_sel`=001, `wd_sel`=3.
  - cycle 5: `done`=1.
- MEM_WAIT=0, `wb_op`=6 -> write in cycle 1 with `regdst_sel`=000, `wd_sel`=1; `done` in cycle 2.
- `wb_op`=3 (JAL), then a second `start` with `wb_op`=1 in cycle 1 -> second request ignored; only one write, `regdst_sel`=010, `wd_sel`=2.
- `wb_op`=7 -> cycle 1 `illegal`=1, `done`=1, no write. Separately, a POP with reset asserted in its WR_A cycle -> next cycle IDLE, no WR_B, no `done`.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback sequencer: op classes, RegDst and write-data
// selects, FSM states and the registered output bundle with its decoder.
package wb_pkg;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_RTYPE   = 3'd1,
    OP_ITYPE   = 3'd2,
    OP_JAL     = 3'd3,
    OP_PUSH    = 3'd4,
    OP_POP     = 3'd5,
    OP_LOAD    = 3'd6,
    OP_ILLEGAL = 3'd7
  } wb_op_e;

  typedef enum logic [2:0] {
    RD_RT  = 3'b000,
    RD_SP  = 3'b001,
    RD_RA  = 3'b010,
    RD_RD  = 3'b011,
    RD_AUX = 3'b100
  } regdst_e;

  typedef enum logic [1:0] {
    WD_ALU    = 2'd0,
    WD_MEM    = 2'd1,
    WD_PC     = 2'd2,
    WD_SP_ADJ = 2'd3
  } wd_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WR_A,
    ST_WR_B,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic    busy;
    logic    done;
    logic    illegal;
    regdst_e regdst;
    wd_sel_e wd;
    logic    reg_write;
  } wb_out_t;

  // Moore decode: outputs depend only on the state being entered and the latched op.
  function automatic wb_out_t decode_outputs(input state_e st, input wb_op_e op);
    wb_out_t o;
    o      = '0;
    o.busy = (st != ST_IDLE);
    case (st)
      ST_WR_A: begin
        o.reg_write = 1'b1;
        case (op)
          OP_RTYPE: begin o.regdst = RD_RD; o.wd = WD_ALU;    end
          OP_ITYPE: begin o.regdst = RD_RT; o.wd = WD_ALU;    end
          OP_JAL:   begin o.regdst = RD_RA; o.wd = WD_PC;     end
          OP_PUSH:  begin o.regdst = RD_SP; o.wd = WD_SP_ADJ; end
          OP_LOAD,
          OP_POP:   begin o.regdst = RD_RT; o.wd = WD_MEM;    end
          default:  begin o.regdst = RD_RT; o.wd = WD_ALU;    end
        endcase
      end
      ST_WR_B: begin
        o.reg_write = 1'b1;
        o.regdst    = RD_SP;
        o.wd        = WD_SP_ADJ;
      end
      ST_DONE: begin
        o.done    = 1'b1;
        o.illegal = (op == OP_ILLEGAL);
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// Request/writeback-control bundle between the main control FSM (master) and the
// writeback sequencer (slave).
interface wb_sequencer_if;
  logic       start;
  logic [2:0] wb_op;
  logic       busy;
  logic       done;
  logic       illegal;
  logic [2:0] regdst_sel;
  logic [1:0] wd_sel;
  logic       reg_write;

  modport master (
    output start, wb_op,
    input  busy, done, illegal, regdst_sel, wd_sel, reg_write
  );

  modport slave (
    input  start, wb_op,
    output busy, done, illegal, regdst_sel, wd_sel, reg_write
  );
endinterface

// File: rtl/wb_sequencer.sv
// Multicycle writeback sequencer: latches a writeback class on start, waits out
// memory latency when needed and drives one or two register-file write cycles.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic           clk,
  input  logic           reset,
  wb_sequencer_if.slave  bus
);

  localparam int CLOG = $clog2(MEM_WAIT + 1);
  localparam int CW   = (CLOG > 1) ? CLOG : 1;

  state_e        state_q, state_d;
  wb_op_e        op_q,    op_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  wb_out_t       out_q,   out_d;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d = wb_op_e'(bus.wb_op);
          case (op_d)
            OP_NONE,
            OP_ILLEGAL: state_d = ST_DONE;
            OP_LOAD,
            OP_POP: begin
              if (MEM_WAIT == 0) begin
                state_d = ST_WR_A;
              end else begin
                state_d = ST_WAIT;
                cnt_d   = CW'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
              end
            end
            default:    state_d = ST_WR_A;
          endcase
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_WR_A;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_WR_A: state_d = (op_q == OP_POP) ? ST_WR_B : ST_DONE;
      ST_WR_B: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Decoding the next state lets the outputs be flopped yet line up with the state.
    out_d = decode_outputs(state_d, op_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy       = out_q.busy;
  assign bus.done       = out_q.done;
  assign bus.illegal    = out_q.illegal;
  assign bus.regdst_sel = out_q.regdst;
  assign bus.wd_sel     = out_q.wd;
  assign bus.reg_write  = out_q.reg_write;

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer: two instances (MEM_WAIT=2 and MEM_WAIT=0) get the
// same stimulus; a cycle-level reference model queues expected outputs per instance.
module tb_wb_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       illegal;
    logic [2:0] rd;
    logic [1:0] wd;
    logic       we;
  } vec_t;

  localparam vec_t V_IDLE = '0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   mon_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  vec_t exp2[$];
  vec_t exp0[$];

  wb_sequencer_if bus2();
  wb_sequencer_if bus0();

  wb_sequencer #(.MEM_WAIT(2)) dut_w2 (.clk(clk), .reset(reset), .bus(bus2));
  wb_sequencer #(.MEM_WAIT(0)) dut_w0 (.clk(clk), .reset(reset), .bus(bus0));

  always #5 clk = ~clk;

  function automatic vec_t wr(input logic [2:0] rd, input logic [1:0] wd);
    vec_t v = '0;
    v.busy = 1'b1; v.rd = rd; v.wd = wd; v.we = 1'b1;
    return v;
  endfunction

  function automatic vec_t fin(input logic ill);
    vec_t v = '0;
    v.busy = 1'b1; v.done = 1'b1; v.illegal = ill;
    return v;
  endfunction

  // Expected per-cycle outputs of one operation, starting with the current (idle) cycle.
  task automatic enqueue(input int which, input int n, input logic [2:0] op);
    vec_t seq[$];
    vec_t wait_v = '0;
    wait_v.busy = 1'b1;
    seq.push_back(V_IDLE);
    case (op)
      3'd0: seq.push_back(fin(1'b0));
      3'd7: seq.push_back(fin(1'b1));
      3'd1: begin seq.push_back(wr(3'b011, 2'd0)); seq.push_back(fin(1'b0)); end
      3'd2: begin seq.push_back(wr(3'b000, 2'd0)); seq.push_back(fin(1'b0)); end
      3'd3: begin seq.push_back(wr(3'b010, 2'd2)); seq.push_back(fin(1'b0)); end
      3'd4: begin seq.push_back(wr(3'b001, 2'd3)); seq.push_back(fin(1'b0)); end
      3'd6: begin
        for (int i = 0; i < n; i++) seq.push_back(wait_v);
        seq.push_back(wr(3'b000, 2'd1));
        seq.push_back(fin(1'b0));
      end
      default: begin
        for (int i = 0; i < n; i++) seq.push_back(wait_v);
        seq.push_back(wr(3'b000, 2'd1));
        seq.push_back(wr(3'b001, 2'd3));
        seq.push_back(fin(1'b0));
      end
    endcase
    foreach (seq[i]) begin
      if (which == 2) exp2.push_back(seq[i]);
      else            exp0.push_back(seq[i]);
    end
  endtask

  task automatic check(input string name, input vec_t act, input vec_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got busy=%b done=%b illegal=%b regdst=%b wd=%0d we=%b, expected busy=%b done=%b illegal=%b regdst=%b wd=%0d we=%b",
               name, $time, act.busy, act.done, act.illegal, act.rd, act.wd, act.we,
               exp.busy, exp.done, exp.illegal, exp.rd, exp.wd, exp.we);
    end
  endtask

  // One clock of stimulus; the model accepts a start only when the instance is idle.
  task automatic step(input logic rst, input logic st, input logic [2:0] op);
    @(posedge clk);
    #1;
    reset       = rst;
    bus2.start  = st; bus2.wb_op = op;
    bus0.start  = st; bus0.wb_op = op;
    mon_en      = 1'b1;
    if (rst) begin
      while (exp2.size() > 1) void'(exp2.pop_back());
      while (exp0.size() > 1) void'(exp0.pop_back());
    end else if (st) begin
      if (exp2.size() == 0) enqueue(2, 2, op);
      if (exp0.size() == 0) enqueue(0, 0, op);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      vec_t e;
      e = V_IDLE;
      if (exp2.size() > 0) e = exp2.pop_front();
      check("w2_outputs", {bus2.busy, bus2.done, bus2.illegal, bus2.regdst_sel, bus2.wd_sel, bus2.reg_write}, e);
      e = V_IDLE;
      if (exp0.size() > 0) e = exp0.pop_front();
      check("w0_outputs", {bus0.busy, bus0.done, bus0.illegal, bus0.regdst_sel, bus0.wd_sel, bus0.reg_write}, e);
    end
  end

  initial begin
    int guard;
    bus2.start = 1'b0; bus2.wb_op = 3'd0;
    bus0.start = 1'b0; bus0.wb_op = 3'd0;

    // Reset held with a pending RTYPE request, then released with no request.
    repeat (4) step(1'b1, 1'b1, 3'd1);
    repeat (3) step(1'b0, 1'b0, 3'd0);

    step(1'b0, 1'b1, 3'd1); repeat (4) step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd5); repeat (7) step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd6); repeat (6) step(1'b0, 1'b0, 3'd0);
    // JAL with a second request in cycle 1 that must be dropped.
    step(1'b0, 1'b1, 3'd3); step(1'b0, 1'b1, 3'd1); repeat (5) step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd7); repeat (3) step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd2); repeat (3) step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd4); repeat (3) step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd0); repeat (3) step(1'b0, 1'b0, 3'd0);
    // POP aborted by reset sampled at the end of its WR_A cycle (MEM_WAIT=2 instance).
    step(1'b0, 1'b1, 3'd5); step(1'b0, 1'b0, 3'd0); step(1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0); repeat (6) step(1'b0, 1'b0, 3'd0);

    for (int i = 0; i < 3000; i++) begin
      logic       r, s;
      logic [2:0] o;
      r = ($urandom_range(0, 63) == 0);
      s = ($urandom_range(0, 1) == 1);
      o = 3'($urandom_range(0, 7));
      step(r, s, o);
    end

    guard = 0;
    while ((exp2.size() > 0 || exp0.size() > 0) && guard < 40) begin
      step(1'b0, 1'b0, 3'd0);
      guard++;
    end
    if (exp2.size() > 0 || exp0.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d/%0d entries left, expected 0/0", exp2.size(), exp0.size());
    end
    repeat (2) step(1'b0, 1'b0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
